// File: rtl/snake_ps2_pkg.sv
// snake_ps2_pkg: shared states, command bytes and timing defaults for the PS/2 host blocks
package snake_ps2_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_INHIBIT   = 3'd1;
    localparam state_t ST_START     = 3'd2;
    localparam state_t ST_SEND      = 3'd3;
    localparam state_t ST_WAIT_IDLE = 3'd4;
    localparam state_t ST_DONE      = 3'd5;
    localparam state_t ST_ERROR     = 3'd6;

    localparam logic [7:0] PS2_CMD_SET_LED   = 8'hED;
    localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_ACK           = 8'hFA;

    localparam int PS2_INHIBIT_CYCLES = 5000;
    localparam int PS2_SETUP_CYCLES   = 50;
    localparam int PS2_TIMEOUT_CYCLES = 750000;

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for PS2_CLK/PS2_DAT plus clock falling-edge detect
// Ports: clk, reset_n (sync, active-low); clk_in/dat_in raw pins;
//        clk_s/dat_s synchronized levels; fall one-cycle strobe on a synchronized clock fall.
module ps2_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_s,
    output logic dat_s,
    output logic fall
);
    logic clk_m, dat_m, clk_p;

    // Reset to the idle bus level so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            {clk_m, clk_s, clk_p, dat_m, dat_s} <= '1;
        end else begin
            clk_m <= clk_in;
            clk_s <= clk_m;
            clk_p <= clk_s;
            dat_m <= dat_in;
            dat_s <= dat_m;
        end
    end

    assign fall = clk_p & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device and checks its ACK
// Ports: clk, reset_n (sync, active-low); tx_data/tx_valid/tx_ready byte handshake;
//        busy (not idle), done/error one-cycle result pulses;
//        ps2_clk_in/ps2_dat_in raw pins; ps2_clk_oe/ps2_dat_oe open-drain pull-low enables.
module ps2_host_tx
    import snake_ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int SETUP_CYCLES   = PS2_SETUP_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam logic [19:0] INH_LAST   = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYCLES - 1);
    localparam logic [19:0] TO_LAST    = 20'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  sh;
    logic        par;
    logic [3:0]  cnt;
    logic [19:0] timer;
    logic        clk_s, dat_s, fall;

    ps2_line_sync u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .clk_in (ps2_clk_in),
        .dat_in (ps2_dat_in),
        .clk_s  (clk_s),
        .dat_s  (dat_s),
        .fall   (fall)
    );

    assign tx_ready = state == ST_IDLE;
    assign busy     = state != ST_IDLE;
    assign done     = state == ST_DONE;
    assign error    = state == ST_ERROR;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            sh         <= '0;
            par        <= 1'b0;
            cnt        <= '0;
            timer      <= '0;
        end else begin
            case (state)
                ST_IDLE: if (tx_valid) begin
                    state      <= ST_INHIBIT;
                    ps2_clk_oe <= 1'b1;
                    sh         <= tx_data;
                    par        <= ~^tx_data;
                    cnt        <= '0;
                    timer      <= '0;
                end
                ST_INHIBIT: if (timer == INH_LAST) begin
                    state      <= ST_START;
                    ps2_dat_oe <= 1'b1;
                    timer      <= '0;
                end else begin
                    timer <= timer + 20'd1;
                end
                ST_START: if (timer == SETUP_LAST) begin
                    state      <= ST_SEND;
                    ps2_clk_oe <= 1'b0;
                    timer      <= '0;
                end else begin
                    timer <= timer + 20'd1;
                end
                // A fall in the terminal-count cycle still counts as a fall.
                ST_SEND: if (fall) begin
                    timer <= '0;
                    cnt   <= cnt + 4'd1;
                    if (cnt < 4'd8) begin
                        ps2_dat_oe <= ~sh[0];
                        sh         <= sh >> 1;
                    end else if (cnt == 4'd8) begin
                        ps2_dat_oe <= ~par;
                    end else if (cnt == 4'd9) begin
                        ps2_dat_oe <= 1'b0;
                    end else begin
                        state <= dat_s ? ST_ERROR : ST_WAIT_IDLE;
                    end
                end else if (timer == TO_LAST) begin
                    state      <= ST_ERROR;
                    ps2_dat_oe <= 1'b0;
                end else begin
                    timer <= timer + 20'd1;
                end
                ST_WAIT_IDLE: if (clk_s & dat_s) begin
                    state <= ST_DONE;
                end else if (fall) begin
                    timer <= '0;
                end else if (timer == TO_LAST) begin
                    state <= ST_ERROR;
                end else begin
                    timer <= timer + 20'd1;
                end
                default: begin
                    state      <= ST_IDLE;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx against a behavioural PS/2 device model
module tb_ps2_host_tx;
    localparam int INH   = 100;
    localparam int SETUP = 20;
    localparam int TO    = 500;
    localparam int H     = 20;

    logic       clk = 1'b0, reset_n = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready, busy, done, error, clk_oe, dat_oe;
    logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
    logic       clk_line, dat_line;

    assign clk_line = !(clk_oe || dev_clk_low);
    assign dat_line = !(dat_oe || dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .ps2_clk_in(clk_line),
        .ps2_dat_in(dat_line),
        .ps2_clk_oe(clk_oe),
        .ps2_dat_oe(dat_oe)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // mode 0: device ACKs, 1: device withholds ACK, 2: device never clocks
    typedef struct {
        logic [7:0] d;
        int         m;
    } exp_t;
    exp_t sb[$];

    // Device model: after request-to-send, clock 11 pulses, read each bit at the clock rise.
    int         dev_mode = 0, dev_falls = 0;
    logic       dev_idle = 1'b1;
    logic [9:0] bits = '0;

    initial forever begin
        @(negedge clk);
        if (reset_n && clk_line && !dat_line) begin
            dev_idle  = 1'b0;
            dev_falls = 0;
            if (dev_mode == 2) begin
                while (!dat_line) @(negedge clk);
            end else begin
                for (int k = 0; k < 11; k++) begin
                    repeat (H / 2) @(negedge clk);
                    if (k == 10 && dev_mode == 0) dev_dat_low = 1'b1;
                    repeat (H / 2) @(negedge clk);
                    dev_clk_low = 1'b1;
                    repeat (H) @(negedge clk);
                    if (k < 10) bits[k] = dat_line;
                    dev_clk_low = 1'b0;
                    dev_falls   = k + 1;
                end
                repeat (H) @(negedge clk);
                dev_dat_low = 1'b0;
                repeat (4) @(negedge clk);
            end
            dev_idle = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each done/error pulse.
    logic prev_clk_oe = 1'b0, pend = 1'b0;
    int   rise_cyc = 0, rel_cyc = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset_n) begin
            if (pend) chk("ready_after_pulse", tx_ready, 1);
            if (!prev_clk_oe && clk_oe) rise_cyc <= cyc;
            if (prev_clk_oe && !clk_oe && busy) begin
                chk("inhibit_plus_setup", cyc - rise_cyc, INH + SETUP);
                rel_cyc <= cyc;
            end
            if (done || error) begin
                chk("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("outcome_done", done, int'(mon_e.m == 0));
                    chk("not_both", done && error, 0);
                    chk("oe_released", {clk_oe, dat_oe}, 0);
                    if (mon_e.m == 2) begin
                        chk("timeout_cycles", cyc - rel_cyc, TO);
                    end else begin
                        chk("byte", bits[7:0], mon_e.d);
                        chk("parity", bits[8], ~^mon_e.d);
                        chk("stop", bits[9], 1);
                    end
                end
            end
        end
        pend        <= reset_n && (done || error);
        prev_clk_oe <= clk_oe;
    end

    task automatic send(input logic [7:0] d, input int m, input bit push);
        int n = 0;
        while ((!dev_idle || !tx_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", tx_ready && dev_idle, 1);
        dev_mode = m;
        tx_data  = d;
        tx_valid = 1'b1;
        if (push) sb.push_back('{d, m});
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accept_clk_oe", clk_oe, 1);
    endtask

    task automatic finish_tx();
        int n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("completed_in_time", tx_ready, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_dat_oe", dat_oe, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        send(8'hED, 0, 1'b1); finish_tx();
        send(8'h01, 0, 1'b1); finish_tx();
        send(8'hFF, 0, 1'b1); finish_tx();
        send(8'($urandom), 2, 1'b1); finish_tx();
        send(8'($urandom), 1, 1'b1); finish_tx();

        send(8'hED, 0, 1'b0);
        n = 0;
        while (dev_falls < 5 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_bit4", int'(dev_falls >= 5), 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_clk_oe", clk_oe, 0);
        chk("midrst_dat_oe", dat_oe, 0);
        chk("midrst_tx_ready", tx_ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_error", error, 0);
        reset_n = 1'b1;
        send(8'hFF, 0, 1'b1); finish_tx();

        send(8'hED, 0, 1'b1);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_for_55", tx_ready, 1);
        sb.push_back('{8'h55, 0});
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accepted_55", busy, 1);
        finish_tx();

        repeat (8) begin
            send(8'($urandom), int'($urandom_range(0, 1)), 1'b1);
            finish_tx();
        end

        repeat (20) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
